mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
Bus responder that services CPU load/store/fetch requests on one request/acknowledge interface. It decodes each address to either the DualBRAM (drives its port B) or a small bank of memory-mapped I/O registers (LEDs, switches, free-running timer, scratch). It is the target side of the CPU memory interface: the CPU issues req/we/addr/wdata, and this block answers with ack/rdata. The CPU must wait for ack before advancing.

Parameters:
ADDR_WIDTH, 10, word address width; matches the BRAM depth of 1024 words.
DATA_WIDTH, 16, data word width.
IO_PAGE, 6'h3F, value of addr[9:4] that selects the I/O page (addresses 0x3F0-0x3FF).
TIMER_PRESCALE, 50000, clk cycles per timer increment; must be at least 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
req  input  1  CPU request; held high until ack is seen.
we  input  1  1 = write, 0 = read; sampled with req.
addr  input  10  word address.
wdata  input  16  write data.
ack  output  1  one-cycle completion pulse.
rdata  output  16  read data; valid with ack and held until the next ack.
bram_addr  output  10  to BRAM port B address.
bram_we  output  1  to BRAM port B write enable.
bram_wdata  output  16  to BRAM port B data.
bram_q  input  16  BRAM port B registered read data; valid one cycle after the address.
switches  input  10  asynchronous board switches.
leds  output  10  LED register contents.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State becomes IDLE.
  - ack=0, rdata=0, bram_we=0, leds=0.
  - Timer, prescaler counter, scratch and switch synchronizer all clear to 0.
  - Reset mid-transaction aborts the transaction: no ack is issued and no BRAM write occurs after reset.
- FSM states: IDLE, BRAM_WAIT, RESP.
- IDLE:
  - If req=1, latch addr, we and wdata. The transaction is "accepted".
  - If addr[9:4]==IO_PAGE, the next state is RESP. An I/O write takes effect at the accept edge; for an I/O read, rdata loads at the accept edge.
  - Otherwise the next state is BRAM_WAIT.
- BRAM_WAIT:
  - bram_addr = latched addr; bram_wdata = latched wdata.
  - bram_we = latched we, asserted for exactly this one cycle.
  - Next state is RESP. For a read, rdata <= bram_q at the edge leaving RESP-entry; concretely, rdata loads from bram_q on the first edge in which bram_q reflects the latched address, so it is valid when ack rises.
- RESP:
  - ack=1 for exactly one cycle; next state is IDLE.
  - For writes, rdata is unchanged.
- Latency, measured from the accept edge to the cycle where ack=1:
  - I/O: 1 cycle.
  - BRAM: 2 cycles.
  - The CPU must drop req or present a new request after ack. req is only sampled in IDLE, so a req still high in the cycle after ack begins a new transaction.
- bram_we is never asserted for I/O addresses. bram_addr is don't-care outside BRAM_WAIT but is driven with the latched address.
- I/O map (other bits read as 0):
  - 0x3F0 LED: read/write, bits [9:0].
  - 0x3F1 switches: read-only, passed through a 2-flop synchronizer; writes are ignored.
  - 0x3F2 timer: 16-bit; increments when the prescaler reaches TIMER_PRESCALE-1, after which the prescaler returns to 0. Wraps 0xFFFF->0x0000. A write loads the timer with wdata and clears the prescaler. If a write and a tick occur in the same cycle, the write wins.
  - 0x3F3 scratch: read/write, 16 bits.
  - 0x3F4-0x3FF: reads return 0; writes are ignored.
- A timer read returns the value present at the accept edge.

Test Plan:
1. Reset: assert rst for 2 cycles while req=1 and addr=0x005 -> ack=0, rdata=0, leds=0, bram_we stays 0 throughout.
2. BRAM read/write: write 0xBEEF to 0x005 -> bram_we high for exactly 1 cycle with bram_addr=0x005, ack 2 cycles after accept. Then read 0x005 -> rdata=0xBEEF with ack 2 cycles after accept.
3. I/O: write 0x2AB to 0x3F0 -> leds=0x2AB, ack 1 cycle after accept, bram_we never 1. Read 0x3F0 -> rdata=0x02AB. Write 0x1234 to 0x3F4, then read it -> rdata=0x0000.
4. Switches: set switches=0x155 -> a read of 0x3F1 issued 3 or more cycles later returns 0x0155. Write 0xFFFF to 0x3F1 -> a subsequent read still returns 0x0155.
5. Timer (TIMER_PRESCALE=4): write 0xFFFE to 0x3F2, idle 8 cycles, read 0x3F2 -> 0x0000 (wrapped). Write timarily on the tick cycle -> the written value is held with no increment for 4 cycles.
6. Back-to-back: hold req=1 across two BRAM reads to 0x001 and 0x002 -> two single-cycle ack pulses 3 cycles apart, with rdata matching each address.

Source files
------------

// File: rtl/mem_io_responder.sv
// mem_io_responder: target side of the CPU memory bus. Each request is routed
// either to port B of the dual-port BRAM or to a small page of memory-mapped
// I/O registers (LEDs, synchronised switches, prescaled timer, scratch).
// The response is a single-cycle ack with read data that holds until the next ack.
module mem_io_responder #(
  parameter int          ADDR_WIDTH     = 10,
  parameter int          DATA_WIDTH     = 16,
  parameter logic [5:0]  IO_PAGE        = 6'h3F,
  parameter int          TIMER_PRESCALE = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_we,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_q,
  input  logic [9:0]            switches,
  output logic [9:0]            leds
);

  // A prescale of 1 still needs a one-bit counter that simply stays at zero.
  localparam int PRESC_W = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TIMER_PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BRAM_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Transaction latched at the accept edge.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  io_q, io_d;

  // Read data register and I/O state.
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [9:0]            leds_q, leds_d;
  logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
  logic [15:0]           timer_q, timer_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [9:0]            sw_meta_q, sw_sync_q;

  logic                  accept;
  logic                  addr_is_io;
  logic                  io_wr;
  logic                  bram_rd_resp;
  logic                  tick;
  logic [DATA_WIDTH-1:0] io_rdata;

  assign addr_is_io = (addr[ADDR_WIDTH-1 -: 6] == IO_PAGE);
  assign io_wr      = accept && addr_is_io && we;
  assign tick       = (presc_q == PRESC_LAST);

  // A BRAM read answers straight from the registered BRAM output during RESP,
  // because that is the first cycle in which bram_q reflects the latched address.
  assign bram_rd_resp = (state_q == RESP) && !io_q && !we_q;

  assign rdata      = bram_rd_resp ? bram_q : rdata_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign leds       = leds_q;

  // State register and all latched/architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      io_q      <= 1'b0;
      rdata_q   <= '0;
      leds_q    <= '0;
      scratch_q <= '0;
      timer_q   <= '0;
      presc_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      io_q      <= io_d;
      rdata_q   <= rdata_d;
      leds_q    <= leds_d;
      scratch_q <= scratch_d;
      timer_q   <= timer_d;
      presc_q   <= presc_d;
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Next-state logic and per-state outputs of the request handshake.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ack     = 1'b0;
    bram_we = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          state_d = addr_is_io ? RESP : BRAM_WAIT;
        end
      end
      BRAM_WAIT: begin
        bram_we = we_q;
        state_d = RESP;
      end
      RESP: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // I/O page read multiplexer; unmapped offsets read as zero.
  always_comb begin
    io_rdata = '0;
    unique case (addr[3:0])
      4'h0:    io_rdata = DATA_WIDTH'(leds_q);
      4'h1:    io_rdata = DATA_WIDTH'(sw_sync_q);
      4'h2:    io_rdata = DATA_WIDTH'(timer_q);
      4'h3:    io_rdata = scratch_q;
      default: io_rdata = '0;
    endcase
  end

  // Request latching, read data capture and I/O register writes.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    io_d      = io_q;
    rdata_d   = rdata_q;
    leds_d    = leds_q;
    scratch_d = scratch_q;
    if (accept) begin
      addr_d  = addr;
      wdata_d = wdata;
      we_d    = we;
      io_d    = addr_is_io;
      if (addr_is_io && !we) begin
        rdata_d = io_rdata;
      end
    end
    // Keep the BRAM word once the response cycle ends so rdata holds.
    if (bram_rd_resp) begin
      rdata_d = bram_q;
    end
    if (io_wr && addr[3:0] == 4'h0) begin
      leds_d = wdata[9:0];
    end
    if (io_wr && addr[3:0] == 4'h3) begin
      scratch_d = wdata;
    end
  end

  // Free-running timer; a CPU write overrides a coincident tick.
  always_comb begin
    timer_d = timer_q;
    presc_d = presc_q + 1'b1;
    if (io_wr && addr[3:0] == 4'h2) begin
      timer_d = 16'(wdata);
      presc_d = '0;
    end else if (tick) begin
      timer_d = timer_q + 16'd1;
      presc_d = '0;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed testbench for mem_io_responder with a behavioural BRAM on port B.
module tb_mem_io_responder;

  localparam int PRESCALE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [9:0]  addr;
  logic [15:0] wdata;
  logic        ack;
  logic [15:0] rdata;
  logic [9:0]  bram_addr;
  logic        bram_we;
  logic [15:0] bram_wdata;
  logic [15:0] bram_q;
  logic [9:0]  switches;
  logic [9:0]  leds;

  int errors = 0;
  int checks = 0;
  logic [15:0] last_rdata = 16'h0000;

  logic [15:0] mem [0:1023];

  mem_io_responder #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(16),
    .IO_PAGE(6'h3F),
    .TIMER_PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .ack(ack),
    .rdata(rdata),
    .bram_addr(bram_addr),
    .bram_we(bram_we),
    .bram_wdata(bram_wdata),
    .bram_q(bram_q),
    .switches(switches),
    .leds(leds)
  );

  always #5 clk = ~clk;

  // Registered-read BRAM port B model.
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_q <= mem[bram_addr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction: I/O acks 1 cycle after accept, BRAM 2 cycles.
  task automatic txn(input logic w, input logic [9:0] a, input logic [15:0] d,
                     input logic [15:0] exp, input string tag);
    bit io;
    int lat;
    io  = (a[9:4] == 6'h3F);
    lat = io ? 1 : 2;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) req = 1'b0;
      check({tag, "_ack"}, {15'b0, ack}, (c == lat) ? 16'd1 : 16'd0);
      check({tag, "_bram_we"}, {15'b0, bram_we}, (!io && w && c == 1) ? 16'd1 : 16'd0);
      if (!io && c == 1) begin
        check({tag, "_bram_addr"}, {6'b0, bram_addr}, {6'b0, a});
        if (w) check({tag, "_bram_wdata"}, bram_wdata, d);
      end
    end
    if (!w) begin
      check({tag, "_rdata"}, rdata, exp);
      last_rdata = exp;
    end else begin
      check({tag, "_rdata_held"}, rdata, last_rdata);
    end
    $display("txn %s we=%0d addr=%h wdata=%h rdata=%h", tag, w, a, d, rdata);
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b1; we = 1'b1; addr = 10'h005; wdata = 16'hDEAD;
    switches = 10'h000;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;

    // Reset held for two cycles with a pending write request.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ack", {15'b0, ack}, 16'd0);
      check("rst_rdata", rdata, 16'h0000);
      check("rst_leds", {6'b0, leds}, 16'h0000);
      check("rst_bram_we", {15'b0, bram_we}, 16'd0);
      $display("reset cycle %0d ack=%0d rdata=%h leds=%h", i, ack, rdata, leds);
    end
    rst = 1'b0; req = 1'b0;

    // BRAM write then read.
    txn(1'b1, 10'h005, 16'hBEEF, 16'h0000, "bram_wr");
    txn(1'b0, 10'h005, 16'h0000, 16'hBEEF, "bram_rd");

    // LED register and unmapped I/O.
    txn(1'b1, 10'h3F0, 16'h02AB, 16'h0000, "led_wr");
    check("led_out", {6'b0, leds}, 16'h02AB);
    txn(1'b0, 10'h3F0, 16'h0000, 16'h02AB, "led_rd");
    txn(1'b1, 10'h3F4, 16'h1234, 16'h0000, "unm_wr");
    txn(1'b0, 10'h3F4, 16'h0000, 16'h0000, "unm_rd");

    // Switches through the synchroniser; writes ignored.
    @(negedge clk);
    switches = 10'h155;
    repeat (3) @(posedge clk);
    txn(1'b0, 10'h3F1, 16'h0000, 16'h0155, "sw_rd");
    txn(1'b1, 10'h3F1, 16'hFFFF, 16'h0000, "sw_wr");
    txn(1'b0, 10'h3F1, 16'h0000, 16'h0155, "sw_rd2");

    // Timer: load 0xFFFE at edge W; ticks land at W+4, W+8, W+12, W+16.
    txn(1'b1, 10'h3F2, 16'hFFFE, 16'h0000, "tmr_wr");
    repeat (8) @(posedge clk);
    txn(1'b0, 10'h3F2, 16'h0000, 16'h0000, "tmr_wrap");       // accept W+10
    txn(1'b1, 10'h3F2, 16'h1234, 16'h0000, "tmr_wr_tick");    // accept W+12, tick edge
    txn(1'b0, 10'h3F2, 16'h0000, 16'h1234, "tmr_hold1");      // accept W+14
    txn(1'b0, 10'h3F2, 16'h0000, 16'h1234, "tmr_hold3");      // accept W+16
    txn(1'b0, 10'h3F2, 16'h0000, 16'h1235, "tmr_inc");        // accept W+18

    // Scratch register.
    txn(1'b1, 10'h3F3, 16'hA5C3, 16'h0000, "scr_wr");
    txn(1'b0, 10'h3F3, 16'h0000, 16'hA5C3, "scr_rd");

    // Back-to-back BRAM reads with req held high.
    txn(1'b1, 10'h001, 16'h1111, 16'h0000, "b2b_wr1");
    txn(1'b1, 10'h002, 16'h2222, 16'h0000, "b2b_wr2");
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'h001;
    @(posedge clk);
    @(negedge clk);
    check("b2b_c1_ack", {15'b0, ack}, 16'd0);
    @(negedge clk);
    check("b2b_c2_ack", {15'b0, ack}, 16'd1);
    check("b2b_c2_rdata", rdata, 16'h1111);
    $display("b2b first ack rdata=%h", rdata);
    addr = 10'h002;
    @(negedge clk);
    check("b2b_c3_ack", {15'b0, ack}, 16'd0);
    @(negedge clk);
    check("b2b_c4_ack", {15'b0, ack}, 16'd0);
    @(negedge clk);
    check("b2b_c5_ack", {15'b0, ack}, 16'd1);
    check("b2b_c5_rdata", rdata, 16'h2222);
    $display("b2b second ack rdata=%h", rdata);
    req = 1'b0;
    @(negedge clk);
    check("b2b_c6_ack", {15'b0, ack}, 16'd0);
    check("b2b_c6_rdata", rdata, 16'h2222);
    last_rdata = 16'h2222;

    // Reset in the middle of a BRAM read aborts it.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 10'h005;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    check("abort_ack", {15'b0, ack}, 16'd0);
    check("abort_rdata", rdata, 16'h0000);
    check("abort_leds", {6'b0, leds}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ack2", {15'b0, ack}, 16'd0);
    $display("abort ack=%0d rdata=%h leds=%h", ack, rdata, leds);
    last_rdata = 16'h0000;
    txn(1'b0, 10'h005, 16'h0000, 16'hBEEF, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
